// File: rtl/pack_unsigned_stream.sv
// Streaming unsigned LEB128 encoder: takes one N-bit value per input handshake and
// emits its minimal byte sequence, least-significant 7-bit group first.
module pack_unsigned_stream #(
    parameter int N = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(N/7+1):0]       out_len
);
    localparam int MB = N / 7 + 1;
    localparam int LW = $clog2(MB) + 1;

    logic [N-1:0]  r_sh;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] r_len;
    logic          r_valid;

    logic [MB-1:0] w_grp_nz;
    logic [LW-1:0] w_len;
    logic          w_last;
    logic          w_in_xfer;
    logic          w_out_xfer;

    // w_grp_nz[g] is set when any bit at or above group g is set.
    genvar gi;
    generate
        for (gi = 0; gi < MB; gi++) begin : g_grp
            assign w_grp_nz[gi] = |(in_data >> (7 * gi));
        end
    endgenerate

    always_comb begin
        w_len = LW'(1);
        for (int g = 1; g < MB; g++) begin
            if (w_grp_nz[g]) begin
                w_len = LW'(g + 1);
            end
        end
    end

    assign w_last     = (r_rem == LW'(1));
    assign in_ready   = !rst && (!r_valid || (out_ready && w_last));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh    <= '0;
            r_rem   <= LW'(1);
            r_len   <= '0;
            r_valid <= 1'b0;
        end else if (w_in_xfer) begin
            // Covers both the idle load and the reload on the last beat.
            r_sh    <= in_data;
            r_rem   <= w_len;
            r_len   <= w_len;
            r_valid <= 1'b1;
        end else if (w_out_xfer) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_sh  <= r_sh >> 7;
                r_rem <= r_rem - LW'(1);
            end
        end
    end

    assign out_byte  = {!w_last, r_sh[6:0]};
    assign out_valid = r_valid;
    assign out_last  = r_valid && w_last;
    assign out_len   = r_len;
endmodule

// File: tb/tb_pack_unsigned_stream.sv
// Directed and randomised checks for pack_unsigned_stream with a byte scoreboard
// and a software LEB128 decoder closing the round trip.
module tb_pack_unsigned_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [4:0]  out_len;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic [4:0] len;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] val_q[$];

    pack_unsigned_stream #(.N(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void push_value(input logic [63:0] v);
        logic [63:0] t;
        logic [7:0]  bs[10];
        int          n;
        t = v;
        n = 0;
        do begin
            bs[n] = {1'b0, t[6:0]};
            t = t >> 7;
            if (t != 0) bs[n][7] = 1'b1;
            n++;
        end while (t != 0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({bs[i], (i == n - 1), 5'(n)});
        end
        val_q.push_back(v);
    endfunction

    // Pseudo-random backpressure, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard, stall stability, in_ready gating, round-trip decode.
    logic [63:0] acc = '0;
    int          nb = 0;
    bit          stalled = 1'b0;
    logic [7:0]  s_byte;
    logic        s_last;
    logic [4:0]  s_len;
    beat_t       e;
    logic [63:0] ev;

    always @(negedge clk) begin
        if (rst) begin
            acc = '0;
            nb = 0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_byte", 64'(out_byte), 64'(s_byte));
                chk("stall_last", 64'(out_last), 64'(s_last));
                chk("stall_len", 64'(out_len), 64'(s_len));
            end
            if (out_valid && !(out_ready && out_last)) begin
                chk("in_ready_busy", 64'(in_ready), 64'(0));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    $display("beat byte=%02h last=%0d len=%0d", out_byte, out_last, out_len);
                    chk("out_byte", 64'(out_byte), 64'(e.b));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("out_len", 64'(out_len), 64'(e.len));
                    acc = acc | (64'(out_byte[6:0]) << (7 * nb));
                    nb++;
                    if (out_last) begin
                        if (val_q.size() != 0) begin
                            ev = val_q.pop_front();
                            chk("roundtrip_value", acc, ev);
                            chk("roundtrip_len", 64'(nb), 64'(out_len));
                        end
                        acc = '0;
                        nb = 0;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            s_byte = out_byte;
            s_last = out_last;
            s_len = out_len;
        end
    end

    // Present v; returns at posedge+1 after acceptance with in_valid still high.
    task automatic send(input logic [63:0] v, output int waits);
        int n;
        n = 0;
        in_data = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        waits = n;
        if (n >= 300) begin
            chk("send_timeout", 64'(n), 64'(0));
            in_valid = 1'b0;
        end else begin
            push_value(v);
            $display("send value=%h", v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n < 1000), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [63:0] v);
        int w;
        send(v, w);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_len", 64'(out_len), 64'(0));
        chk("rst_byte", 64'(out_byte), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        one(64'h0);
        one(64'h7F);
        one(64'h80);
        one(64'h3FFF);
        one(64'h4000);
        one(64'd624485);
        one(64'hFFFF_FFFF_FFFF_FFFF);

        // Held backpressure: in_ready must stay low until the last byte goes.
        out_ready = 1'b0;
        send(64'd624485, w);
        in_data = 64'h55;
        repeat (4) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        rand_rdy = 1'b1;
        one(64'd624485);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: 0x80, 0x05, 0x00 with no output bubbles.
        send(64'h80, w);
        chk("b2b_wait0", 64'(w), 64'(0));
        send(64'h05, w);
        chk("b2b_wait1", 64'(w), 64'(1));
        send(64'h00, w);
        chk("b2b_wait2", 64'(w), 64'(0));
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", 64'(out_valid), 64'(1));
        chk("b2b_last_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_idle_valid", 64'(out_valid), 64'(0));
        chk("b2b_idle_in_ready", 64'(in_ready), 64'(1));
        drain();

        // Reset after the first byte of 0x4000.
        send(64'h4000, w);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_len", 64'(out_len), 64'(0));
        chk("mid_rst_byte", 64'(out_byte), 64'(0));
        chk("mid_rst_last", 64'(out_last), 64'(0));
        exp_q.delete();
        val_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_release_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_no_bytes", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        one(64'h01);

        // Random round trip under random backpressure, varied lengths.
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            r = r >> $urandom_range(0, 63);
            send(r, w);
        end
        in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pack_unsigned_stream.md
# pack_unsigned_stream

Streaming unsigned LEB128 encoder: accepts one N-bit unsigned value per handshake and emits its minimal LEB128 byte sequence, least-significant 7-bit group first, one byte per accepted output beat. It is the transmit-side counterpart of `unpack_unsigned`: any byte sequence it produces, packed into that decoder's input, yields the original value and the same `len`. It sits between value producers and the byte-stream writer.

## Interface
- `N`, 64: width of the unsigned input value; `MB = N/7+1` is the maximum encoded length in bytes.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  N  value to encode; sampled only on the input handshake.
- `in_valid`  input  1  producer has a value.
- `in_ready`  output  1  encoder can take a value this cycle.
- `out_byte`  output  8  encoded byte: bit 7 is the continuation flag, bits 6:0 are the data group.
- `out_valid`  output  1  `out_byte`, `out_last` and `out_len` are valid.
- `out_ready`  input  1  consumer takes the byte this cycle.
- `out_last`  output  1  current byte is the final byte of the value (bit 7 of `out_byte` is 0).
- `out_len`  output  $clog2(MB)+1  total byte count of the current value, 1..MB; constant for all beats of one value.

## Operation
- Input transfer: `in_valid & in_ready` at a rising edge. Output transfer: `out_valid & out_ready` at a rising edge.
- `in_ready = !rst & (!out_valid | (out_ready & out_last))`. This is combinational from `out_ready`, so a new value is accepted in the same cycle the last byte of the previous value leaves.
- Length: h = index of the highest set bit of `in_data`; length = h/7 + 1; `in_data == 0` gives length 1. The maximum is MB. For N=64, an all-ones value gives 10.
- State:
  - Shift register `sh[N-1:0]`.
  - Remaining count `rem`, range 1..MB.
  - Registered `out_len`.
  - Idle is `out_valid == 0`; busy is `out_valid == 1`.
- On an input transfer:
  - `sh <= in_data`, `rem <= length`, `out_len <= length`, `out_valid <= 1`.
- Output byte, combinational from state: `out_byte = {rem != 1, sh[6:0]}`, `out_last = (rem == 1)`.
- On an output transfer that is not last: `sh <= sh >> 7` (zero fill), `rem <= rem - 1`.
- On an output transfer that is last:
  - If there is a simultaneous input transfer, reload as above.
  - Otherwise `out_valid <= 0`.
- When N is not a multiple of 7, the high bits of the final group are zero through the zero fill.
- Stall: while `out_valid & !out_ready`, every output holds stable. `in_data` is ignored.
- Reset, including mid-value: the partially sent value is discarded with no further bytes.
  - `out_valid=0`, `out_last=0`, `out_len=0`.
  - `sh=0`, `rem=1`, so `out_byte` reads 0x00.
  - `in_ready=0` while `rst` is high, and 1 in the first cycle after `rst` drops.

## Timing
- Latency: an input transfer at edge t puts byte 0 on the output from cycle t+1 (`out_valid` registered).
- A value of length L with `out_ready` held high occupies L consecutive output cycles. With back-to-back `in_valid`, the output stream has no bubbles.
- Input-to-first-byte and byte-to-byte paths are registered. The only combinational path is `out_ready` → `in_ready`.
- Worst-case throughput is 1 byte/cycle. Sustained value rate is 1 value per L cycles.

## Test plan
- Small values, `out_ready`=1:
  - in 0x00 → single beat 0x00, `out_last`=1, `out_len`=1.
  - in 0x7F → single beat 0x7F, `out_len`=1.
- Boundary values:
  - in 0x80 → 0x80, 0x01 (`out_len`=2, `out_last` on the second beat only).
  - in 0x3FFF → 0xFF, 0x7F.
  - in 0x4000 → 0x80, 0x80, 0x01.
- Multi-byte value: in 624485 → 0xE5, 0x8E, 0x26, `out_len`=3. With N=64 all-ones → 0xFF ×9 then 0x01, `out_len`=10.
- Backpressure:
  - in 624485 with `out_ready` toggling pseudo-randomly → same 3 bytes; outputs are stable across every stalled cycle.
  - `in_ready` stays 0 until the last byte transfers.
- Back-to-back: `in_valid` held high with values 0x80, 0x05, 0x00 and `out_ready`=1 → 0x80, 0x01, 0x05, 0x00 on 4 consecutive cycles. `in_ready` is high exactly in the cycles where the last byte transfers, plus the first idle cycle.
- Reset mid-value:
  - Assert `rst` after the first byte of 0x4000 → next cycle `out_valid`=0, `out_len`=0, no further bytes.
  - After `rst` drops, in 0x01 → single byte 0x01.
- Round-trip: random N=64 values are encoded, assembled into the `unpack_unsigned` input with zero-padding, and decoded → output equals the original value and `len` equals `out_len`.
